em_pipe_reg: RTL and testbench

Execute-to-memory pipeline register that sits directly downstream of the execute-stage multiply/divide unit and ALU. Each cycle it captures the execute stage's result (ALU, MDU HI/LO read-out, or link address), forwarding metadata and exception state, and presents them to the memory stage. It also decrements the result-ready countdown (Tnew) and merges execute-stage overflow faults into the exception code. It implements the pipeline's stall, bubble and interrupt-flush rules for this boundary.

---
 rtl/em_pipe_reg_pkg.sv | 50 +++++
 rtl/em_pipe_reg.sv | 115 +++++++++++
 tb/tb_em_pipe_reg.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/em_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : em_pipe_reg_pkg
//  Description : Shared constants for the execute-to-memory pipeline register:
//                exception codes, result-select and execute-fault encodings,
//                default reset/handler PCs and the exception-merge helper.
//  Revision    : 1.0  initial release
// ============================================================================
package em_pipe_reg_pkg;

    // Exception codes as seen by CP0
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Result-source selector (value 3 is treated as ALU)
    localparam logic [1:0] RES_ALU  = 2'd0;
    localparam logic [1:0] RES_MDU  = 2'd1;
    localparam logic [1:0] RES_PC8  = 2'd2;

    // Execute-stage fault encodings
    localparam logic [1:0] OV_NONE  = 2'd0;
    localparam logic [1:0] OV_ARITH = 2'd1;
    localparam logic [1:0] OV_LOAD  = 2'd2;
    localparam logic [1:0] OV_STORE = 2'd3;

    // Default PC values
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;

    // An exception from an earlier stage takes precedence over an execute fault
    function automatic logic [4:0] merge_exc(input logic [4:0] exc_in,
                                             input logic [1:0] ov);
        logic [4:0] r;
        if (exc_in != EXC_NONE) begin
            r = exc_in;
        end else begin
            case (ov)
                OV_ARITH: r = EXC_OV;
                OV_LOAD:  r = EXC_ADEL;
                OV_STORE: r = EXC_ADES;
                default:  r = EXC_NONE;
            endcase
        end
        return r;
    endfunction

endpackage : em_pipe_reg_pkg
`default_nettype wire

// File: rtl/em_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : em_pipe_reg
//  Description : Execute-to-memory pipeline register. Selects the E-stage
//                result, decrements Tnew, merges execute faults into the
//                exception code and applies req/flush/stall rules.
//  Revision    : 1.0  initial release
// ============================================================================
module em_pipe_reg
    import em_pipe_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] E_pc,
    input  logic [31:0] E_instr,
    input  logic [31:0] E_alu,
    input  logic [31:0] E_mdu,
    input  logic [31:0] E_rt_data,
    input  logic [1:0]  E_res_sel,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  E_exccode,
    input  logic [1:0]  E_ov,
    input  logic        E_bd,
    output logic [31:0] M_pc,
    output logic [31:0] M_instr,
    output logic [31:0] M_res,
    output logic [31:0] M_rt_data,
    output logic [4:0]  M_wa,
    output logic [1:0]  M_tnew,
    output logic [4:0]  M_exccode,
    output logic        M_bd,
    output logic        M_valid
);

    logic [31:0] res_d;
    logic [1:0]  tnew_d;
    logic [4:0]  exc_d;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] res_q;
    logic [31:0] rt_data_q;
    logic [4:0]  wa_q;
    logic [1:0]  tnew_q;
    logic [4:0]  exc_q;
    logic        bd_q;
    logic        valid_q;

    // Result select, Tnew countdown and exception merge ahead of the register
    always_comb begin
        res_d = E_alu;
        case (E_res_sel)
            RES_MDU: res_d = E_mdu;
            RES_PC8: res_d = E_pc + 32'd8;
            default: res_d = E_alu;
        endcase
        tnew_d = (E_tnew == 2'd0) ? 2'd0 : (E_tnew - 2'd1);
        exc_d  = merge_exc(E_exccode, E_ov);
    end

    // Pipeline register: reset > req > flush > stall > load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            res_q     <= '0;
            rt_data_q <= '0;
            wa_q      <= '0;
            tnew_q    <= '0;
            exc_q     <= '0;
            bd_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else if (req || flush) begin
            // Both insert a bubble; flush keeps PC/BD so CP0 can form EPC
            pc_q      <= req ? HANDLER_PC : E_pc;
            bd_q      <= req ? 1'b0 : E_bd;
            instr_q   <= '0;
            res_q     <= '0;
            rt_data_q <= '0;
            wa_q      <= '0;
            tnew_q    <= '0;
            exc_q     <= '0;
            valid_q   <= 1'b0;
        end else if (!stall) begin
            pc_q      <= E_pc;
            instr_q   <= E_instr;
            res_q     <= res_d;
            rt_data_q <= E_rt_data;
            wa_q      <= E_wa;
            tnew_q    <= tnew_d;
            exc_q     <= exc_d;
            bd_q      <= E_bd;
            valid_q   <= 1'b1;
        end
    end

    assign M_pc      = pc_q;
    assign M_instr   = instr_q;
    assign M_res     = res_q;
    assign M_rt_data = rt_data_q;
    assign M_wa      = wa_q;
    assign M_tnew    = tnew_q;
    assign M_exccode = exc_q;
    assign M_bd      = bd_q;
    assign M_valid   = valid_q;

endmodule : em_pipe_reg
`default_nettype wire

// File: tb/tb_em_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_em_pipe_reg
//  Description : Self-checking bench for em_pipe_reg with directed steps and
//                randomized traffic against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_em_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, req, flush, stall;
    logic [31:0] E_pc, E_instr, E_alu, E_mdu, E_rt_data;
    logic [1:0]  E_res_sel, E_tnew, E_ov;
    logic [4:0]  E_wa, E_exccode;
    logic        E_bd;
    logic [31:0] M_pc, M_instr, M_res, M_rt_data;
    logic [4:0]  M_wa, M_exccode;
    logic [1:0]  M_tnew;
    logic        M_bd, M_valid;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] x_pc, x_instr, x_res, x_rt;
    logic [4:0]  x_wa, x_exc;
    logic [1:0]  x_tnew;
    logic        x_bd, x_valid;

    em_pipe_reg #(
        .RESET_PC   (32'h0000_3000),
        .HANDLER_PC (32'h0000_4180)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .flush     (flush),
        .stall     (stall),
        .E_pc      (E_pc),
        .E_instr   (E_instr),
        .E_alu     (E_alu),
        .E_mdu     (E_mdu),
        .E_rt_data (E_rt_data),
        .E_res_sel (E_res_sel),
        .E_wa      (E_wa),
        .E_tnew    (E_tnew),
        .E_exccode (E_exccode),
        .E_ov      (E_ov),
        .E_bd      (E_bd),
        .M_pc      (M_pc),
        .M_instr   (M_instr),
        .M_res     (M_res),
        .M_rt_data (M_rt_data),
        .M_wa      (M_wa),
        .M_tnew    (M_tnew),
        .M_exccode (M_exccode),
        .M_bd      (M_bd),
        .M_valid   (M_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    M_pc,              x_pc);
        chk({tag, ".instr"}, M_instr,           x_instr);
        chk({tag, ".res"},   M_res,             x_res);
        chk({tag, ".rt"},    M_rt_data,         x_rt);
        chk({tag, ".wa"},    {27'd0, M_wa},     {27'd0, x_wa});
        chk({tag, ".tnew"},  {30'd0, M_tnew},   {30'd0, x_tnew});
        chk({tag, ".exc"},   {27'd0, M_exccode}, {27'd0, x_exc});
        chk({tag, ".bd"},    {31'd0, M_bd},     {31'd0, x_bd});
        chk({tag, ".valid"}, {31'd0, M_valid},  {31'd0, x_valid});
    endtask

    task automatic model_reset();
        x_pc = 32'h0000_3000; x_instr = 0; x_res = 0; x_rt = 0;
        x_wa = 0; x_tnew = 0; x_exc = 0; x_bd = 0; x_valid = 0;
    endtask

    task automatic model_bubble(input logic [31:0] pc, input logic bd);
        x_pc = pc; x_bd = bd; x_instr = 0; x_res = 0; x_rt = 0;
        x_wa = 0; x_tnew = 0; x_exc = 0; x_valid = 0;
    endtask

    // What the register should hold after the coming edge
    task automatic model_edge();
        int t;
        if (req) begin
            model_bubble(32'h0000_4180, 1'b0);
        end else if (flush) begin
            model_bubble(E_pc, E_bd);
        end else if (!stall) begin
            x_pc = E_pc; x_instr = E_instr; x_rt = E_rt_data; x_wa = E_wa; x_bd = E_bd;
            x_valid = 1'b1;
            if (E_res_sel == 2'd1)      x_res = E_mdu;
            else if (E_res_sel == 2'd2) x_res = 32'((64'(E_pc) + 64'd8) % 64'h1_0000_0000);
            else                        x_res = E_alu;
            t = int'(E_tnew) - 1;
            x_tnew = (t < 0) ? 2'd0 : 2'(t);
            if (E_exccode != 0)   x_exc = E_exccode;
            else if (E_ov == 2'd1) x_exc = 5'd12;
            else if (E_ov == 2'd2) x_exc = 5'd4;
            else if (E_ov == 2'd3) x_exc = 5'd5;
            else                   x_exc = 5'd0;
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic rand_inputs();
        E_pc = $urandom; E_instr = $urandom; E_alu = $urandom; E_mdu = $urandom;
        E_rt_data = $urandom; E_res_sel = 2'($urandom); E_wa = 5'($urandom);
        E_tnew = 2'($urandom); E_ov = 2'($urandom); E_bd = 1'($urandom);
        E_exccode = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
    endtask

    initial begin
        // Reset held low with busy inputs
        reset = 1'b0; req = 1'b0; flush = 1'b0; stall = 1'b0;
        rand_inputs();
        E_pc = 32'hABCD_0000;
        #12;
        model_reset();
        check_all("reset");
        // Release away from the edge; first capture at the next rising edge
        @(negedge clk);
        reset = 1'b1;
        E_alu = 32'h1234; E_res_sel = 2'd0; E_wa = 5'd8; E_tnew = 2'd1;
        E_exccode = 0; E_ov = 0;
        tick("first");
        chk("first.res_lit", M_res, 32'h0000_1234);

        // Result select
        E_res_sel = 2'd1; E_mdu = 32'hDEAD_BEEF;
        tick("sel_mdu");
        E_res_sel = 2'd2; E_pc = 32'hFFFF_FFFC; E_tnew = 2'd0;
        tick("sel_pc8");
        chk("pc8_wrap_lit", M_res, 32'h0000_0004);
        E_res_sel = 2'd3; E_alu = 32'h5555_AAAA; E_tnew = 2'd3;
        tick("sel_3");

        // Exception merge
        E_exccode = 5'd0;  E_ov = 2'd1; tick("exc_ov");
        chk("exc_ov_lit", {27'd0, M_exccode}, 32'd12);
        E_exccode = 5'd10; E_ov = 2'd1; tick("exc_pass");
        E_exccode = 5'd0;  E_ov = 2'd2; tick("exc_adel");
        E_exccode = 5'd0;  E_ov = 2'd3; tick("exc_ades");
        E_ov = 2'd0; E_wa = 5'd0; tick("exc_none");

        // Stall for 3 edges while inputs change, then resume
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            tick("stall");
        end
        stall = 1'b0;
        rand_inputs();
        tick("unstall");

        // Flush keeps PC/BD
        flush = 1'b1; E_pc = 32'h3010; E_bd = 1'b1; E_wa = 5'd7;
        tick("flush");
        flush = 1'b0;
        rand_inputs(); tick("post_flush");

        // Flush beats stall
        flush = 1'b1; stall = 1'b1; E_pc = 32'h3014; E_bd = 1'b0;
        tick("flush_stall");
        flush = 1'b0; stall = 1'b0;
        rand_inputs(); tick("reload");

        // req beats stall
        req = 1'b1; stall = 1'b1; E_pc = 32'h3020; E_bd = 1'b1;
        tick("req_stall");
        req = 1'b0; stall = 1'b0;
        rand_inputs(); tick("pre_async");

        // Asynchronous reset between edges
        #2 reset = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            rand_inputs();
            req   = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_em_pipe_reg
`default_nettype wire
